echo_delay_proc: RTL and testbench

Echo/feedback-delay stage between the SPI ADC interface and the SPI DAC interface. Consumes one 10-bit offset-binary ADC sample per `data_valid` pulse and computes y[n] = x[n] + y[n−D]·2^−GAIN_SHIFT using a circular delay buffer in block RAM. Presents the result in offset-binary on `data_out` for the DAC, which loads it on its next sampling tick.

---
 rtl/echo_delay_proc_pkg.sv | 23 ++
 rtl/echo_delay_proc_if.sv | 13 +
 rtl/echo_delay_proc_ram.sv | 28 ++
 rtl/echo_delay_proc.sv | 122 ++++++++++++
 tb/tb_echo_delay_proc.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/echo_delay_proc_pkg.sv
// echo_pkg: shared state encoding, mid-scale constant and saturating narrow for the echo stage.
package echo_pkg;

   localparam int unsigned SAMPLE_W = 10;

   localparam logic [SAMPLE_W-1:0] MID_SCALE = {1'b1, {(SAMPLE_W-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      CALC  = 2'd2,
      WRITE = 2'd3
   } state_t;

   // Narrow a one-bit-wider two's-complement sum, clamping on overflow.
   function automatic logic signed [SAMPLE_W-1:0] sat_add(input logic signed [SAMPLE_W:0] sum);
      if (sum[SAMPLE_W] != sum[SAMPLE_W-1])
         return sum[SAMPLE_W] ? {1'b1, {(SAMPLE_W-1){1'b0}}} : {1'b0, {(SAMPLE_W-1){1'b1}}};
      else
         return sum[SAMPLE_W-1:0];
   endfunction

endpackage

// File: rtl/echo_delay_proc_if.sv
// Sample bus between the ADC interface (master), the echo stage (slave) and the DAC.
interface echo_delay_proc_if #(
   parameter int unsigned DATA_W = 10
) ();
   logic [DATA_W-1:0] data_in;
   logic              data_valid;
   logic [DATA_W-1:0] data_out;
   logic              out_valid;
   logic              overrun;

   modport master (output data_in, data_valid, input data_out, out_valid, overrun);
   modport slave  (input data_in, data_valid, output data_out, out_valid, overrun);
endinterface

// File: rtl/echo_delay_proc_ram.sv
// echo_delay_ram: simple dual-port delay buffer with registered read, shaped for block-RAM inference.
module echo_delay_ram #(
   parameter int unsigned DATA_W = 10,
   parameter int unsigned ADDR_W = 13
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic              i_re,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
);
   localparam int unsigned DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rdata;

   // No reset on the array or read register so the tools map this onto a RAM macro.
   always_ff @(posedge clk) begin
      if (i_we)
         r_mem[i_waddr] <= i_wdata;
      if (i_re)
         r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;
endmodule

// File: rtl/echo_delay_proc.sv
// echo_delay_proc: y[n] = x[n] + y[n-D] * 2^-GAIN_SHIFT over a circular RAM delay line.
// Build option: define ECHO_SAT_EN to saturate the sum; otherwise it wraps to DATA_W bits.
module echo_delay_proc
   import echo_pkg::*;
#(
   parameter int unsigned DATA_W     = SAMPLE_W,
   parameter int unsigned ADDR_W     = 13,
   parameter int unsigned GAIN_SHIFT = 1
) (
   input  logic             sysclk,
   input  logic             rst_n,
   echo_delay_proc_if.slave bus
);

   state_t                   r_state, w_state_nxt;
   logic signed [DATA_W-1:0] r_x, w_x_nxt;
   logic signed [DATA_W-1:0] r_y, w_y_nxt;
   logic [DATA_W-1:0]        r_data_out, w_data_out_nxt;
   logic                     r_out_valid, w_out_valid_nxt;
   logic                     r_overrun, w_overrun_nxt;
   logic                     r_filled, w_filled_nxt;
   logic [ADDR_W-1:0]        r_wr_ptr, w_wr_ptr_nxt;
   logic                     w_ram_we, w_ram_re;
   logic [DATA_W-1:0]        w_ram_rdata;
   logic signed [DATA_W-1:0] w_yd, w_fb, w_y;

   echo_delay_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk     (sysclk),
      .i_we    (w_ram_we & rst_n),
      .i_waddr (r_wr_ptr),
      .i_wdata (r_y),
      .i_re    (w_ram_re),
      .i_raddr (r_wr_ptr),
      .o_rdata (w_ram_rdata)
   );

   // Feedback is forced to zero until the buffer has been written end to end once.
   assign w_yd = r_filled ? w_ram_rdata : '0;
   assign w_fb = w_yd >>> GAIN_SHIFT;

`ifdef ECHO_SAT_EN
   logic signed [DATA_W:0] w_sum;
   assign w_sum = {r_x[DATA_W-1], r_x} + {w_fb[DATA_W-1], w_fb};
   assign w_y   = sat_add(w_sum);
`else
   assign w_y   = r_x + w_fb;
`endif

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_x         <= '0;
         r_y         <= '0;
         r_data_out  <= MID_SCALE;
         r_out_valid <= 1'b0;
         r_overrun   <= 1'b0;
         r_filled    <= 1'b0;
         r_wr_ptr    <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_x         <= w_x_nxt;
         r_y         <= w_y_nxt;
         r_data_out  <= w_data_out_nxt;
         r_out_valid <= w_out_valid_nxt;
         r_overrun   <= w_overrun_nxt;
         r_filled    <= w_filled_nxt;
         r_wr_ptr    <= w_wr_ptr_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_x_nxt         = r_x;
      w_y_nxt         = r_y;
      w_data_out_nxt  = r_data_out;
      w_out_valid_nxt = 1'b0;
      w_overrun_nxt   = r_overrun;
      w_filled_nxt    = r_filled;
      w_wr_ptr_nxt    = r_wr_ptr;
      w_ram_we        = 1'b0;
      w_ram_re        = 1'b0;

      // Strobes outside IDLE are dropped and flagged.
      if (bus.data_valid && (r_state != IDLE))
         w_overrun_nxt = 1'b1;

      case (r_state)
         IDLE: begin
            if (bus.data_valid) begin
               w_x_nxt     = {~bus.data_in[DATA_W-1], bus.data_in[DATA_W-2:0]};
               w_state_nxt = READ;
            end
         end
         READ: begin
            w_ram_re    = 1'b1;
            w_state_nxt = CALC;
         end
         CALC: begin
            w_y_nxt     = w_y;
            w_state_nxt = WRITE;
         end
         WRITE: begin
            w_ram_we        = 1'b1;
            w_data_out_nxt  = {~r_y[DATA_W-1], r_y[DATA_W-2:0]};
            w_out_valid_nxt = 1'b1;
            w_wr_ptr_nxt    = r_wr_ptr + ADDR_W'(1);
            if (r_wr_ptr == {ADDR_W{1'b1}})
               w_filled_nxt = 1'b1;
            w_state_nxt     = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign bus.data_out  = r_data_out;
   assign bus.out_valid = r_out_valid;
   assign bus.overrun   = r_overrun;

endmodule

// File: tb/tb_echo_delay_proc.sv
// Randomised self-checking bench for echo_delay_proc (ADDR_W = 3) against a sample-history model.
module tb_echo_delay_proc;

   localparam int unsigned DATA_W     = 10;
   localparam int unsigned ADDR_W     = 3;
   localparam int unsigned GAIN_SHIFT = 1;
   localparam int          DEPTH      = 2**ADDR_W;

   logic sysclk;
   logic rst_n;

   echo_delay_proc_if #(.DATA_W(DATA_W)) bus ();

   echo_delay_proc #(
      .DATA_W     (DATA_W),
      .ADDR_W     (ADDR_W),
      .GAIN_SHIFT (GAIN_SHIFT)
   ) dut (
      .sysclk (sysclk),
      .rst_n  (rst_n),
      .bus    (bus)
   );

   initial sysclk = 1'b0;
   always #5 sysclk = ~sysclk;

   int unsigned n_vec      = 0;
   int unsigned n_miss     = 0;
   int unsigned pulse_cnt  = 0;
   int unsigned exp_pulses = 0;
   int          hist[$];

   always @(negedge sysclk)
      if (rst_n && bus.out_valid) pulse_cnt++;

   task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: offset-binary in/out, y = x + y[n-D] >>> GAIN_SHIFT over the sample history.
   function automatic logic [31:0] model_step(input logic [9:0] din);
      int n, x, yd, fb, sum, y;
      n   = hist.size();
      x   = int'(din) - 512;
      yd  = (n >= DEPTH) ? hist[n-DEPTH] : 0;
      fb  = yd >>> GAIN_SHIFT;
      sum = x + fb;
`ifdef ECHO_SAT_EN
      y = (sum > 511) ? 511 : ((sum < -512) ? -512 : sum);
`else
      y = ((sum % 1024) + 1024) % 1024;
      if (y >= 512) y = y - 1024;
`endif
      hist.push_back(y);
      return 32'(y + 512);
   endfunction

   task automatic do_reset();
      rst_n          = 1'b0;
      bus.data_valid = 1'b0;
      repeat (3) @(posedge sysclk);
      #1 rst_n = 1'b1;
      hist.delete();
   endtask

   // One sample through the full handshake with fixed-latency output checks.
   task automatic apply(input logic [9:0] d, input int unsigned gap);
      logic [31:0] e;
      @(posedge sysclk); #1;
      bus.data_in    = d;
      bus.data_valid = 1'b1;
      @(posedge sysclk); #1;
      bus.data_valid = 1'b0;
      bus.data_in    = 10'($urandom);
      e = model_step(d);
      exp_pulses++;
      repeat (2) @(posedge sysclk);
      #1 chk_val("ov_early", 32'(bus.out_valid), 32'd0);
      @(posedge sysclk); #1;
      chk_val("ov_lat", 32'(bus.out_valid), 32'd1);
      chk_val("dout", 32'(bus.data_out), e);
      @(posedge sysclk); #1;
      chk_val("ov_pulse", 32'(bus.out_valid), 32'd0);
      repeat (gap) @(posedge sysclk);
      #1 chk_val("dout_hold", 32'(bus.data_out), e);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] e;
      int unsigned p0;
      rst_n          = 1'b0;
      bus.data_valid = 1'b0;
      bus.data_in    = '0;

      do_reset();
      #1;
      chk_val("rst_dout", 32'(bus.data_out), 32'h200);
      chk_val("rst_ov", 32'(bus.out_valid), 32'd0);
      chk_val("rst_ovr", 32'(bus.overrun), 32'd0);
      repeat (12) @(posedge sysclk);
      #1 chk_val("no_spurious", pulse_cnt, 32'd0);

      // Impulse response: echoes at 8, 16, 24 halving each time.
      apply(10'h300, 14);
      for (int i = 1; i < 28; i++) apply(10'h200, 14);

      do_reset();
      for (int i = 0; i < 10; i++) apply(10'h2FF, 2);

      do_reset();
      for (int i = 0; i < 10; i++) apply(10'h3FF, 2);

      do_reset();
      for (int i = 0; i < 60; i++) apply(10'($urandom), $urandom_range(0, 4));
      #1 chk_val("ovr_clear", 32'(bus.overrun), 32'd0);

      // Overrun: second strobe lands in READ and must be discarded.
      p0 = pulse_cnt;
      @(posedge sysclk); #1;
      bus.data_in    = 10'($urandom);
      bus.data_valid = 1'b1;
      e = model_step(bus.data_in);
      exp_pulses++;
      @(posedge sysclk); #1;
      bus.data_in    = 10'($urandom);
      bus.data_valid = 1'b1;
      @(posedge sysclk); #1;
      bus.data_valid = 1'b0;
      @(posedge sysclk); #1;
      chk_val("ovr_early", 32'(bus.out_valid), 32'd0);
      @(posedge sysclk); #1;
      chk_val("ovr_ov", 32'(bus.out_valid), 32'd1);
      chk_val("ovr_dout", 32'(bus.data_out), e);
      chk_val("ovr_flag", 32'(bus.overrun), 32'd1);
      repeat (6) @(posedge sysclk);
      #1 chk_val("ovr_one_pulse", pulse_cnt - p0, 32'd1);
      for (int i = 0; i < 12; i++) apply(10'($urandom), $urandom_range(0, 3));
      chk_val("ovr_sticky", 32'(bus.overrun), 32'd1);

      // Reset while in CALC: in-flight sample is abandoned.
      @(posedge sysclk); #1;
      bus.data_in    = 10'h3A5;
      bus.data_valid = 1'b1;
      @(posedge sysclk); #1;
      bus.data_valid = 1'b0;
      @(posedge sysclk); #1;
      rst_n = 1'b0;
      #1;
      chk_val("mid_dout", 32'(bus.data_out), 32'h200);
      chk_val("mid_ovr", 32'(bus.overrun), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(posedge sysclk); #1;
         chk_val("mid_ov", 32'(bus.out_valid), 32'd0);
      end
      rst_n = 1'b1;
      hist.delete();
      for (int i = 0; i < 20; i++) apply(10'($urandom), $urandom_range(0, 3));

      repeat (5) @(posedge sysclk);
      #1 chk_val("pulses", pulse_cnt, 32'(exp_pulses));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
